seq_mult_unit: RTL and testbench

- Parametrised sequential shift-add multiplier: a radix-2 datapath and its controller in one block.
- Accepts two WIDTH-bit operands on a start/done handshake. Runtime mode selects signed (two's complement) or unsigned operation.
- Produces a 2*WIDTH-bit product plus a sign flag.
- Sits under the arithmetic top level; replaces the hand-sequenced multiplier datapath that needed an external controller to drive load, shift and accumulate selects.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_mult_abs.sv | 15 +
 rtl/seq_mult_unit.sv | 135 +++++++++++++
 tb/tb_seq_mult_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and the iteration-counter width helper.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational magnitude extractor: two's complement negation when the value
// is signed and negative; the most negative value maps to 2^(WIDTH-1) unsigned.
module seq_mult_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             is_signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  assign sign_o = is_signed_i & value_i[WIDTH-1];
  assign mag_o  = sign_o ? (-value_i) : value_i;

endmodule

// File: rtl/seq_mult_unit.sv
// Radix-2 sequential multiplier (controller + datapath) with a start/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to leave RUN once the remaining multiplier bits are zero.
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 is_neg
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [PW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      product_q, product_d;
  logic               is_neg_q, is_neg_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic               run_exit;

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value_i     (in_a),
    .is_signed_i (is_signed),
    .mag_o       (mag_a),
    .sign_o      (sign_a)
  );

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value_i     (in_b),
    .is_signed_i (is_signed),
    .mag_o       (mag_b),
    .sign_o      (sign_b)
  );

  // NOTE: state register uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: datapath registers are all reset so an aborted operation leaves no
  // residue; there is no memory array here that would make this costly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      is_neg_q  <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      is_neg_q  <= is_neg_d;
    end
  end

  // NOTE: every signal driven here gets a default first, otherwise paths that
  // leave it unassigned would infer latches.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    is_neg_d  = is_neg_q;
    run_exit  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{WIDTH{1'b0}}, mag_a};
          b_d     = mag_b;
          acc_d   = '0;
          count_d = '0;
          neg_d   = (sign_a ^ sign_b) & (|in_a) & (|in_b);
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        acc_d   = acc_q + (b_q[0] ? a_q : '0);
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        run_exit = (count_d == CNT_W'(WIDTH)) || (b_d == '0);
`else
        run_exit = (count_d == CNT_W'(WIDTH));
`endif
        if (run_exit) state_d = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        product_d = neg_q ? (-acc_q) : acc_q;
        is_neg_d  = neg_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign is_neg  = is_neg_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit (WIDTH=8); latency expectations
// follow SEQ_MULT_EARLY_TERM_EN when it is defined for the build.
module tb_seq_mult_unit;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        is_neg;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_prev = '0;

  seq_mult_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .is_neg    (is_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one multiply and measures latency as the number of rising edges,
  // counting the accepting edge, until done is seen high.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] ep, input logic en, input int elat,
                          input bit poke, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    in_a = a; in_b = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (lat == 2) begin
          check(busy, 1, {tag, " busy mid-run"});
          check(product, exp_prev, {tag, " product held"});
          if (poke) begin
            start = 1'b1; in_a = 8'd7; in_b = 8'd7;
          end
        end
        @(posedge clk);
        lat++;
        #1 start = 1'b0;
      end
    end
    check(got, 1, {tag, " done seen"});
    check(lat, elat, {tag, " latency"});
    check(product, ep, {tag, " product"});
    check(is_neg, en, {tag, " is_neg"});
    check(busy, 0, {tag, " busy low at done"});
    @(negedge clk);
    check(done, 0, {tag, " done one cycle"});
    check(busy, 0, {tag, " idle after done"});
    exp_prev = ep;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check(busy, 0, "reset busy");
    check(done, 0, "reset done");
    check(product, 16'h0000, "reset product");
    check(is_neg, 0, "reset is_neg");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_mult(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1, EARLY ? 5 : 10, 1'b0, "s -3x5");
    run_mult(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 10, 1'b0, "s -128x-128");
    run_mult(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 10, 1'b0, "u 255x255");
    run_mult(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, EARLY ? 3 : 10, 1'b0, "s -1x-1");
    run_mult(8'h07, 8'hFE, 1'b1, 16'hFFF2, 1'b1, EARLY ? 4 : 10, 1'b0, "s 7x-2");
    run_mult(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1, EARLY ? 9 : 10, 1'b0, "s -128x127");

    // Abort 12x12 mid-run; outputs must clear with no clock edge.
    @(negedge clk);
    in_a = 8'd12; in_b = 8'd12; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(busy, 1, "pre-abort busy");
    rst = 1'b1;
    #1;
    check(busy, 0, "abort busy");
    check(done, 0, "abort done");
    check(product, 16'h0000, "abort product");
    check(is_neg, 0, "abort is_neg");
    exp_prev = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check(busy, 0, "no residue after abort");

    run_mult(8'd12, 8'd12, 1'b0, 16'h0090, 1'b0, EARLY ? 6 : 10, 1'b0, "u 12x12");
    run_mult(8'h00, 8'hFB, 1'b1, 16'h0000, 1'b0, EARLY ? 5 : 10, 1'b1, "s 0x-5 poke");
    run_mult(8'd100, 8'd1, 1'b0, 16'h0064, 1'b0, EARLY ? 3 : 10, 1'b0, "u 100x1");
    run_mult(8'd100, 8'd200, 1'b0, 16'h4E20, 1'b0, 10, 1'b0, "u 100x200");
    run_mult(8'd5, 8'd0, 1'b0, 16'h0000, 1'b0, EARLY ? 3 : 10, 1'b0, "u 5x0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
